// File: rtl/riscv_pkg.sv
// riscv_pkg: funct3 encodings shared by the memory stage and its data memory.
package riscv_pkg;
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_NONE = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] f3);
    case (f3)
      F3_B:    return {{56{raw[7]}}, raw[7:0]};
      F3_H:    return {{48{raw[15]}}, raw[15:0]};
      F3_W:    return {{32{raw[31]}}, raw[31:0]};
      F3_D:    return raw;
      F3_BU:   return {56'd0, raw[7:0]};
      F3_HU:   return {48'd0, raw[15:0]};
      F3_WU:   return {32'd0, raw[31:0]};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/data_mem.sv
// data_mem: byte-addressed memory with sized little-endian access that wraps
// modulo MEM_BYTES; stores land on negedge clk, loads are combinational.
module data_mem
  import riscv_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata
);
  logic [7:0]  mem [MEM_BYTES];
  logic [63:0] raw;
  logic [3:0]  nbytes;

  assign nbytes = (funct3 == F3_NONE) ? 4'd0 : 4'd1 << funct3[1:0];

  // Always gather eight bytes; the extension step trims to the access size.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[addr + ADDR_W'(i)];
  end

  assign rdata = re ? load_ext(raw, funct3) : '0;

  always_ff @(negedge clk)
    for (int i = 0; i < 8; i++)
      if (we && reset && 4'(i) < nbytes) mem[addr + ADDR_W'(i)] <= wdata[8*i +: 8];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: branch resolution, data memory access and the MEM/WB register
// of the five-stage RISC-V pipeline.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        is_greater,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [63:0] PCplusimm,
  input  logic [63:0] ALU_result,
  input  logic [63:0] WriteData,
  input  logic [3:0]  funct_in,
  input  logic [4:0]  rd,
  output logic        PCSrc,
  output logic [63:0] branch_target,
  output logic        RegWrite_wb,
  output logic        MemtoReg_wb,
  output logic [63:0] ReadData_wb,
  output logic [63:0] ALU_result_wb,
  output logic [4:0]  rd_wb,
  output logic [63:0] wb_data
);
  logic [2:0]  f3;
  logic        unused_funct7;
  logic        cond;
  logic [63:0] read_data;

  assign f3 = funct_in[2:0];
  assign unused_funct7 = funct_in[3];

  data_mem #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .reset(reset),
    .we(MemWrite),
    .re(MemRead),
    .funct3(f3),
    .addr(ALU_result[ADDR_W-1:0]),
    .wdata(WriteData),
    .rdata(read_data)
  );

  // is_greater and Zero together encode the signed compare from EX.
  assign cond = (f3 == F3_BEQ) ? Zero :
                (f3 == F3_BNE) ? !Zero :
                (f3 == F3_BLT) ? (!Zero && !is_greater) :
                (f3 == F3_BGE) ? (Zero || is_greater) : 1'b0;
  assign PCSrc = Branch & cond;
  assign branch_target = PCplusimm;

  always_ff @(negedge clk or negedge reset)
    if (!reset) begin
      RegWrite_wb   <= 1'b0;
      MemtoReg_wb   <= 1'b0;
      ReadData_wb   <= '0;
      ALU_result_wb <= '0;
      rd_wb         <= '0;
    end else begin
      RegWrite_wb   <= RegWrite;
      MemtoReg_wb   <= MemtoReg;
      ReadData_wb   <= read_data;
      ALU_result_wb <= ALU_result;
      rd_wb         <= rd;
    end

  assign wb_data = MemtoReg_wb ? ReadData_wb : ALU_result_wb;
endmodule
